// File: rtl/stack_tracked_if.sv
// ---------------------------------------------------------------------------
// stack_tracked_if -- command/status bundle for the stack_tracked block.
//
// Signals:
//   we        host -> stack   load head with wd this cycle
//   delta     host -> stack   2'b01 push, 2'b11 pop, 2'b00/2'b10 no move
//   wd        host -> stack   write data
//   clr_err   host -> stack   clear the sticky overflow/underflow flags
//   rd        stack -> host   top of stack (head register)
//   rd2       stack -> host   second entry (tail entry 0)
//   depth     stack -> host   count of valid words, 0..DEPTH+1
//   empty     stack -> host   depth == 0
//   full      stack -> host   depth == DEPTH+1
//   overflow  stack -> host   sticky: push attempted while full
//   underflow stack -> host   sticky: pop attempted while empty
//
// Modports: master (host side), slave (stack side).
// ---------------------------------------------------------------------------
interface stack_tracked_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 18
);
    localparam int DW = $clog2(DEPTH + 2);

    logic             we;
    logic [1:0]       delta;
    logic [WIDTH-1:0] wd;
    logic             clr_err;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] rd2;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output we, delta, wd, clr_err,
        input  rd, rd2, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  we, delta, wd, clr_err,
        output rd, rd2, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_tracked.sv
// ---------------------------------------------------------------------------
// stack_tracked -- shift-register stack (head register plus DEPTH tail
// entries) with a saturating occupancy count and sticky overflow/underflow.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    stack_tracked_if.slave (we, delta, wd, clr_err in;
//          rd, rd2, depth, empty, full, overflow, underflow out)
//
// Data always shifts on push/pop regardless of occupancy: a push while full
// drops the bottom word, a pop while empty still shifts FILL up from the
// bottom. Only the count saturates. Every output is taken straight from a
// register (or a compare of the count register), so there is no
// combinational input-to-output path.
// ---------------------------------------------------------------------------
module stack_tracked #(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 18,
    parameter logic [WIDTH-1:0] FILL  = WIDTH'(16'h55aa)
) (
    input  logic           clk,
    input  logic           reset,
    stack_tracked_if.slave bus
);
    localparam int            DW   = $clog2(DEPTH + 2);
    localparam logic [DW-1:0] MAXC = DW'(DEPTH + 1);

    logic [WIDTH-1:0] head,   head_n;
    logic [WIDTH-1:0] tail   [DEPTH];
    logic [WIDTH-1:0] tail_n [DEPTH];
    logic [DW-1:0]    cnt,    cnt_n;
    logic             ovf,    ovf_n;
    logic             udf,    udf_n;

    logic is_push, is_pop;
    assign is_push = (bus.delta == 2'b01);
    assign is_pop  = (bus.delta == 2'b11);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        head_n = head;
        tail_n = tail;
        cnt_n  = cnt;
        ovf_n  = ovf & ~bus.clr_err;
        udf_n  = udf & ~bus.clr_err;

        if (is_push) begin
            tail_n[0] = head;
            for (int i = 1; i < DEPTH; i++) tail_n[i] = tail[i-1];
            if (bus.we) head_n = bus.wd;        // otherwise head is duplicated
            if (cnt == MAXC) ovf_n = 1'b1;      // a new error beats clr_err
            else             cnt_n = cnt + 1'b1;
        end else if (is_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) tail_n[i] = tail[i+1];
            tail_n[DEPTH-1] = FILL;
            head_n = bus.we ? bus.wd : tail[0];
            if (cnt == '0) udf_n = 1'b1;
            else           cnt_n = cnt - 1'b1;
        end else if (bus.we) begin
            head_n = bus.wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            // NOTE: the tail array is reset explicitly because its contents
            // are architecturally visible (FILL must surface on pops).
            for (int i = 0; i < DEPTH; i++) tail[i] <= FILL;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            head <= head_n;
            tail <= tail_n;
            cnt  <= cnt_n;
            ovf  <= ovf_n;
            udf  <= udf_n;
        end
    end

    assign bus.rd        = head;
    assign bus.rd2       = tail[0];
    assign bus.depth     = cnt;
    assign bus.empty     = (cnt == '0);
    assign bus.full      = (cnt == MAXC);
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;

endmodule

// File: tb/tb_stack_tracked.sv
// ---------------------------------------------------------------------------
// tb_stack_tracked -- scoreboard bench for stack_tracked (default params).
// The reference model keeps the whole DEPTH+1 word store as a queue with the
// top of stack at index 0; each driven cycle pushes the model's expected
// outputs into exp_q, and an independent monitor pops and compares after
// every clock edge and every reset assertion.
// ---------------------------------------------------------------------------
module tb_stack_tracked;
    localparam int          WIDTH = 16;
    localparam int          DEPTH = 18;
    localparam logic [15:0] FILL  = 16'h55aa;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] rd2;
        int          depth;
        bit          empty;
        bit          full;
        bit          ovf;
        bit          udf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_tracked_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_tracked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [15:0] m[$];
    int          m_cnt;
    bit          m_ovf, m_udf;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m.delete();
        m.push_back(16'h0000);
        for (int i = 0; i < DEPTH; i++) m.push_back(FILL);
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(bit w, logic [1:0] d, logic [15:0] v, bit c);
        bit oe = 1'b0;
        bit ue = 1'b0;
        if (d == 2'b01) begin
            m.push_front(w ? v : m[0]);
            void'(m.pop_back());
            if (m_cnt == DEPTH + 1) oe = 1'b1;
            else                    m_cnt++;
        end else if (d == 2'b11) begin
            void'(m.pop_front());
            m.push_back(FILL);
            if (w) m[0] = v;
            if (m_cnt == 0) ue = 1'b1;
            else            m_cnt--;
        end else if (w) begin
            m[0] = v;
        end
        m_ovf = oe | (m_ovf & !c);
        m_udf = ue | (m_udf & !c);
    endtask

    task automatic push_exp();
        exp_t e;
        e.rd    = m[0];
        e.rd2   = m[1];
        e.depth = m_cnt;
        e.empty = (m_cnt == 0);
        e.full  = (m_cnt == DEPTH + 1);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);
    endtask

    // One normal cycle: drive at the falling edge, takes effect at the next
    // rising edge.
    task automatic cyc(bit w, logic [1:0] d, logic [15:0] v, bit c);
        @(negedge clk);
        reset       = 1'b0;
        bus.we      = w;
        bus.delta   = d;
        bus.wd      = v;
        bus.clr_err = c;
        model_step(w, d, v, c);
        push_exp();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Assert reset between edges, with a push burst still being driven, then
    // hold it for n further clock edges with random inputs.
    task automatic assert_reset(int n);
        @(posedge clk);
        #3;
        model_reset();
        push_exp();
        reset = 1'b1;
        #1;
        check("rst_async_rd", bus.rd, 16'h0000);
        check("rst_async_rd2", bus.rd2, FILL);
        check("rst_async_empty", bus.empty, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.we      = 1'($urandom);
            bus.delta   = 2'($urandom);
            bus.wd      = 16'($urandom);
            bus.clr_err = 1'($urandom);
            push_exp();
        end
    endtask

    // Monitor: compares after every rising clock edge and reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rd",        bus.rd,        e.rd);
                check("rd2",       bus.rd2,       e.rd2);
                check("depth",     bus.depth,     e.depth);
                check("empty",     bus.empty,     e.empty);
                check("full",      bus.full,      e.full);
                check("overflow",  bus.overflow,  e.ovf);
                check("underflow", bus.underflow, e.udf);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] d;
        int         drain;
        reset       = 1'b0;
        bus.we      = 1'b0;
        bus.delta   = 2'b00;
        bus.wd      = '0;
        bus.clr_err = 1'b0;
        #1;
        model_reset();
        push_exp();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            push_exp();
        end

        // Push 1,2,3 then pop three times.
        cyc(1, 2'b01, 16'd1, 0);
        cyc(1, 2'b01, 16'd2, 0);
        cyc(1, 2'b01, 16'd3, 0);
        settle();
        check("s028_rd", bus.rd, 16'd3);
        check("s028_rd2", bus.rd2, 16'd2);
        check("s028_depth", bus.depth, 3);
        cyc(0, 2'b11, 16'd0, 0);
        cyc(0, 2'b11, 16'd0, 0);
        cyc(0, 2'b11, 16'd0, 0);
        settle();
        check("s029_rd", bus.rd, 16'd0);
        check("s029_rd2", bus.rd2, FILL);
        check("s029_empty", bus.empty, 1'b1);

        // Pop while empty, then clear.
        cyc(0, 2'b11, 16'd0, 0);
        settle();
        check("s030_udf", bus.underflow, 1'b1);
        check("s030_rd", bus.rd, FILL);
        cyc(0, 2'b00, 16'd0, 1);
        settle();
        check("s030_clr", bus.underflow, 1'b0);

        // Overfill, then drain.
        for (int k = 1; k <= DEPTH + 2; k++) cyc(1, 2'b01, 16'(k), 0);
        settle();
        check("s031_full", bus.full, 1'b1);
        check("s031_ovf", bus.overflow, 1'b1);
        check("s031_depth", bus.depth, DEPTH + 1);
        check("s031_rd", bus.rd, DEPTH + 2);
        for (int k = 0; k < DEPTH; k++) cyc(0, 2'b11, 16'd0, 0);
        settle();
        check("s031_last_rd", bus.rd, 16'd2);
        check("s031_depth1", bus.depth, 1);
        cyc(0, 2'b11, 16'd0, 0);

        // Clear with a simultaneous overflowing push keeps overflow set.
        for (int k = 0; k < DEPTH + 1; k++) cyc(1, 2'b01, 16'(k + 100), 0);
        cyc(1, 2'b01, 16'd999, 1);
        settle();
        check("s033_ovf_kept", bus.overflow, 1'b1);
        cyc(0, 2'b00, 16'd0, 1);
        settle();
        check("s033_ovf_clr", bus.overflow, 1'b0);

        // Write in place at depth 2, then dup push.
        assert_reset(1);
        cyc(1, 2'b01, 16'd1, 0);
        cyc(1, 2'b01, 16'd2, 0);
        cyc(1, 2'b00, 16'd7, 0);
        settle();
        check("s032_rd", bus.rd, 16'd7);
        check("s032_rd2", bus.rd2, 16'd1);
        check("s032_depth", bus.depth, 2);
        cyc(0, 2'b01, 16'd0, 0);
        settle();
        check("s032_dup_rd2", bus.rd2, 16'd7);
        check("s032_dup_depth", bus.depth, 3);

        // Reset in the middle of a push burst.
        for (int k = 0; k < 5; k++) cyc(1, 2'b01, 16'(k + 40), 0);
        assert_reset(2);

        // Randomised traffic; pushes/pops evenly weighted so both ends are hit.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: d = 2'b01;
                4, 5, 6, 7: d = 2'b11;
                8:          d = 2'b00;
                default:    d = 2'b10;
            endcase
            if ($urandom_range(0, 199) == 0) assert_reset(1);
            cyc(1'($urandom), d, 16'($urandom), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        bus.we    = 1'b0;
        bus.delta = 2'b00;
        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk);
            #2;
            drain++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_tracked.md
STACK_TRACKED -- requirements
Module: stack_tracked

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 18, the number of tail entries below head; total capacity is DEPTH+1 words.
REQ-003 SHALL have parameter FILL, default 16'h55aa zero-extended or truncated to WIDTH, the word shifted into the bottom on every pop.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, the reset: asynchronous and active-high.
REQ-006 SHALL have port rd, output, WIDTH, the top of stack (head register).
REQ-007 SHALL have port rd2, output, WIDTH, the second entry (tail entry 0).
REQ-008 SHALL have port we, input, 1, load head with wd this cycle.
REQ-009 SHALL have port delta, input, 2, stack move: 2'b01 push, 2'b11 pop, 2'b00 and 2'b10 no move.
REQ-010 SHALL have port wd, input, WIDTH, the write data.
REQ-011 SHALL have port clr_err, input, 1, clear the sticky error flags.
REQ-012 SHALL have port depth, output, $clog2(DEPTH+2), the count of valid words, 0..DEPTH+1.
REQ-013 SHALL have ports empty and full, output, 1 each, asserted when depth==0 and when depth==DEPTH+1 respectively.
REQ-014 SHALL have ports overflow and underflow, output, 1 each, the sticky error flags.

Function
REQ-015 Push SHALL shift the tail up by one (head into entry 0, entry DEPTH-1 discarded) and set head to wd if we, otherwise leave head unchanged (dup).
REQ-016 Pop SHALL shift the tail down by one (FILL into entry DEPTH-1) and set head to wd if we, otherwise to the old entry 0.
REQ-017 No move with we=1 SHALL set head to wd with the tail unchanged; with we=0, all data SHALL hold.
REQ-018 A push with depth<DEPTH+1 SHALL increment depth; a push at depth==DEPTH+1 SHALL leave depth unchanged, lose the bottom word, and set overflow.
REQ-019 A pop with depth>0 SHALL decrement depth; a pop at depth==0 SHALL still shift the data, leave depth at 0, and set underflow.
REQ-020 A no-move cycle SHALL NOT change depth, including we=1 at depth 0.
REQ-021 overflow and underflow SHALL stay set until a cycle with clr_err=1 and no new error of that kind; a simultaneous new error and clr_err SHALL leave that flag set.
REQ-022 rd, rd2, depth, empty, full, overflow and underflow SHALL be register-derived, with no combinational path from any input.
REQ-023 All effects of an edge SHALL be visible on the outputs in the same cycle after that edge, with one-cycle latency and no stall.
REQ-024 depth arithmetic SHALL saturate; it SHALL never wrap.

Reset
REQ-025 While reset=1, the block SHALL hold head=0, every tail entry=FILL, depth=0, empty=1, full=0, overflow=0 and underflow=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL immediately force the REQ-025 state, and pending inputs on that edge SHALL be ignored.
REQ-027 The first edge after reset deasserts SHALL operate normally.

Verification
REQ-028 Scenario: reset, then push with we for wd=1,2,3 -> rd=3, rd2=2, depth=3, empty=0.
REQ-029 Scenario: from the REQ-028 state, three pops with we=0 -> rd sequence 2,1,0; rd2 ends at FILL; depth=0; empty=1; underflow=0.
REQ-030 Scenario: pop at depth 0 -> underflow=1, depth=0, rd=FILL; then clr_err=1 for one cycle -> underflow=0.
REQ-031 Scenario: DEPTH+2 pushes of values 1..DEPTH+2 -> full=1, overflow=1, depth=DEPTH+1, rd=DEPTH+2; then DEPTH+1 pops -> last rd before empty is 2 (value 1 lost).
REQ-032 Scenario: no move with we=1 and wd=7 at depth 2 -> rd=7, rd2 unchanged, depth=2; push with we=0 -> rd=7, rd2=7, depth=3.
REQ-033 Scenario: reset asserted between edges during a push burst -> outputs take the REQ-025 values without a clock edge; clr_err asserted with a simultaneous overflow push -> overflow stays 1.
